// File: rtl/sine_voice_scheduler.sv
// sine_voice_scheduler: shares one quarter-wave sine ROM across NUM_VOICES phase
// accumulators and sums the signed per-voice samples into one mixed sample per request.
module sine_voice_scheduler #(
  parameter int NUM_VOICES = 3,
  parameter int STEP_W     = 20,
  parameter int PHASE_W    = 22
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         generate_next,
  input  logic [NUM_VOICES-1:0]        voice_en,
  input  logic [NUM_VOICES*STEP_W-1:0] step_sizes,
  output logic [9:0]                   rom_addr,
  input  logic [15:0]                  rom_dout,
  output logic [17:0]                  mix_sample,
  output logic                         sample_ready,
  output logic                         busy,
  output logic                         overrun
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] LAST_V = 2'(NUM_VOICES - 1);

  state_t             r_state;
  state_t             w_state_next;
  logic [1:0]         r_v;
  logic [1:0]         w_v_next;
  logic               w_last_voice;
  logic [PHASE_W-1:0] r_phase [NUM_VOICES];
  logic [STEP_W-1:0]  w_step;
  logic [17:0]        w_sample;
  logic [17:0]        r_acc;
  logic [17:0]        w_acc_next;
  logic [17:0]        r_mix;
  logic [9:0]         r_rom_addr;
  logic [9:0]         w_rom_addr_next;
  logic               r_ready;
  logic               w_ready_next;
  logic               r_busy;
  logic               w_busy_next;
  logic               r_overrun;
  logic               w_overrun_next;

  // Quarter-wave fold: the mirror bit reflects the ROM index within the half period.
  function automatic logic [9:0] fold_addr(input logic [PHASE_W-1:0] ph);
    logic [9:0] idx;
    idx = ph[PHASE_W-3 -: 10];
    return ph[PHASE_W-2] ? ~idx : idx;
  endfunction

  function automatic logic [17:0] signed_sample(input logic [15:0] d, input logic neg);
    logic [17:0] ext;
    ext = {{2{d[15]}}, d};
    return neg ? (18'd0 - ext) : ext;
  endfunction

  assign w_last_voice = (r_v == LAST_V);

  // State and voice-index register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_v     <= 2'd0;
    end else begin
      r_state <= w_state_next;
      r_v     <= w_v_next;
    end
  end

  // Next-state and next-voice selection.
  always_comb begin
    w_state_next = r_state;
    w_v_next     = r_v;
    case (r_state)
      S_IDLE: begin
        if (generate_next) begin
          w_state_next = S_ADDR;
          w_v_next     = 2'd0;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_ADDR: w_state_next = S_DATA;
      S_DATA: begin
        if (w_last_voice) begin
          w_state_next = S_DONE;
        end else begin
          w_state_next = S_ADDR;
          w_v_next     = r_v + 2'd1;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output decode, evaluated one cycle ahead so every output comes straight from a flop.
  always_comb begin
    w_rom_addr_next = 10'd0;
    if (w_state_next == S_ADDR) begin
      w_rom_addr_next = fold_addr(r_phase[w_v_next]);
    end else begin
      w_rom_addr_next = 10'd0;
    end
    w_busy_next    = (w_state_next != S_IDLE);
    w_ready_next   = (w_state_next == S_DONE);
    w_overrun_next = generate_next && (r_state != S_IDLE);
  end

  // Per-voice arithmetic for the voice currently in its DATA cycle.
  always_comb begin
    w_step   = step_sizes[int'(r_v) * STEP_W +: STEP_W];
    w_sample = signed_sample(rom_dout, r_phase[r_v][PHASE_W-1]);
    if (voice_en[r_v]) begin
      w_acc_next = r_acc + w_sample;
    end else begin
      w_acc_next = r_acc;
    end
  end

  // Accumulator, phases and mixed-sample register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_acc <= 18'd0;
      r_mix <= 18'd0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_phase[i] <= {PHASE_W{1'b0}};
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (generate_next) begin
            r_acc <= 18'd0;
          end
        end
        S_DATA: begin
          r_acc <= w_acc_next;
          // A disabled voice restarts from phase zero when it is next enabled.
          if (voice_en[r_v]) begin
            r_phase[r_v] <= r_phase[r_v] + {{(PHASE_W-STEP_W){1'b0}}, w_step};
          end else begin
            r_phase[r_v] <= {PHASE_W{1'b0}};
          end
          if (w_last_voice) begin
            r_mix <= w_acc_next;
          end
        end
        default: ;
      endcase
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rom_addr <= 10'd0;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_rom_addr <= w_rom_addr_next;
      r_ready    <= w_ready_next;
      r_busy     <= w_busy_next;
      r_overrun  <= w_overrun_next;
    end
  end

  assign rom_addr     = r_rom_addr;
  assign mix_sample   = r_mix;
  assign sample_ready = r_ready;
  assign busy         = r_busy;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_sine_voice_scheduler.sv
// Self-checking bench for sine_voice_scheduler: directed scenarios plus random frames
// compared against a frame-level arithmetic model of the voice mixer.
module tb_sine_voice_scheduler;

  localparam int NV        = 3;
  localparam int FRAME_CYC = 2 * NV + 1;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              generate_next;
  logic [NV-1:0]     voice_en;
  logic [NV*20-1:0]  step_sizes;
  logic [9:0]        rom_addr;
  logic [15:0]       rom_dout;
  logic [17:0]       mix_sample;
  logic              sample_ready;
  logic              busy;
  logic              overrun;

  int n_cmp = 0;
  int n_bad = 0;

  logic [21:0] m_phase [NV];
  logic [9:0]  m_addr  [NV];
  logic [17:0] m_mix;

  logic [9:0]  q_addr [9] = '{10'd0, 10'd512, 10'd1023, 10'd511, 10'd0,
                              10'd512, 10'd1023, 10'd511, 10'd0};
  logic [17:0] q_mix  [9] = '{18'd0, 18'd512, 18'd1023, 18'd511, 18'd0,
                              18'h3FE00, 18'h3FC01, 18'h3FE01, 18'd0};

  always #5 clk = ~clk;

  // ROM stand-in: data is the address itself, one cycle later.
  always @(posedge clk) rom_dout <= {6'b0, rom_addr};

  sine_voice_scheduler #(.NUM_VOICES(NV), .STEP_W(20), .PHASE_W(22)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .generate_next(generate_next),
    .voice_en     (voice_en),
    .step_sizes   (step_sizes),
    .rom_addr     (rom_addr),
    .rom_dout     (rom_dout),
    .mix_sample   (mix_sample),
    .sample_ready (sample_ready),
    .busy         (busy),
    .overrun      (overrun)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One frame of the sine mixer computed with plain integer arithmetic.
  task automatic model_frame();
    int acc;
    int a;
    acc = 0;
    for (int v = 0; v < NV; v++) begin
      a = int'(m_phase[v][19:10]);
      if (m_phase[v][20]) a = 1023 - a;
      m_addr[v] = 10'(a);
      if (m_phase[v][21]) a = -a;
      if (voice_en[v]) begin
        acc = acc + a;
        m_phase[v] = m_phase[v] + 22'(step_sizes[v*20 +: 20]);
      end else begin
        m_phase[v] = 22'd0;
      end
    end
    m_mix = 18'(acc);
  endtask

  task automatic model_reset();
    for (int v = 0; v < NV; v++) m_phase[v] = 22'd0;
    m_mix = 18'd0;
  endtask

  // Runs a frame and checks every cycle; inj>0 pulses generate_next during cycle inj.
  task automatic do_frame(input int inj, output logic [17:0] got_mix, output logic [9:0] got_a0);
    logic [17:0] prev;
    prev = m_mix;
    model_frame();
    got_mix = 18'd0;
    got_a0  = 10'd0;
    @(negedge clk);
    generate_next = 1'b1;
    for (int k = 1; k <= FRAME_CYC + 2; k++) begin
      @(negedge clk);
      generate_next = (k == inj);
      if (k == 1) begin
        check_eq("mix_hold", mix_sample, prev);
        got_a0 = rom_addr;
      end
      if ((k % 2 == 1) && (k < FRAME_CYC))
        check_eq("rom_addr", rom_addr, m_addr[(k-1)/2]);
      else
        check_eq("rom_addr_zero", rom_addr, 32'd0);
      check_eq("ready", sample_ready, (k == FRAME_CYC));
      check_eq("busy", busy, (k <= FRAME_CYC));
      check_eq("overrun", overrun, (inj > 0) && (k == inj + 1));
      if (k >= FRAME_CYC) check_eq("mix", mix_sample, m_mix);
      if (k == FRAME_CYC) got_mix = mix_sample;
    end
    generate_next = 1'b0;
  endtask

  task automatic set_steps(input logic [19:0] s0, input logic [19:0] s1, input logic [19:0] s2);
    step_sizes = {s2, s1, s0};
  endtask

  initial begin
    logic [17:0] gm;
    logic [9:0]  ga;

    reset_n       = 1'b0;
    generate_next = 1'b1;
    voice_en      = 3'b000;
    step_sizes    = '0;
    model_reset();

    // Reset held with a request pending.
    repeat (4) @(negedge clk);
    check_eq("rst_busy", busy, 32'd0);
    check_eq("rst_ready", sample_ready, 32'd0);
    check_eq("rst_mix", mix_sample, 32'd0);
    check_eq("rst_addr", rom_addr, 32'd0);
    check_eq("rst_ovr", overrun, 32'd0);
    generate_next = 1'b0;
    reset_n       = 1'b1;
    repeat (2) @(negedge clk);

    // Basic single voice, two frames 10 cycles apart.
    voice_en = 3'b001;
    set_steps(20'h00400, 20'h0, 20'h0);
    do_frame(0, gm, ga);
    check_eq("basic_mix0", gm, 32'd0);
    do_frame(0, gm, ga);
    check_eq("basic_mix1", gm, 32'd1);

    // All voices disabled: full-length frame, zero mix, phases cleared.
    voice_en = 3'b000;
    do_frame(0, gm, ga);
    check_eq("alloff_mix", gm, 32'd0);

    // Quadrants and phase wrap.
    voice_en = 3'b001;
    set_steps(20'h80000, 20'h0, 20'h0);
    for (int f = 0; f < 9; f++) begin
      do_frame(0, gm, ga);
      check_eq("quad_addr", ga, q_addr[f]);
      check_eq("quad_mix", gm, q_mix[f]);
    end

    // Three-voice mix.
    voice_en = 3'b000;
    do_frame(0, gm, ga);
    voice_en = 3'b111;
    set_steps(20'h00400, 20'h00800, 20'h00C00);
    do_frame(0, gm, ga);
    do_frame(0, gm, ga);
    check_eq("mix3", gm, 32'd6);

    // Overrun mid-frame and in DONE, then voice 0 disabled and re-enabled.
    voice_en = 3'b001;
    set_steps(20'h12345, 20'h0, 20'h0);
    do_frame(3, gm, ga);
    do_frame(FRAME_CYC, gm, ga);
    voice_en = 3'b000;
    do_frame(0, gm, ga);
    voice_en = 3'b001;
    do_frame(0, gm, ga);
    check_eq("reenable_addr0", ga, 32'd0);

    // Reset in the middle of a frame.
    voice_en = 3'b111;
    set_steps(20'h0A000, 20'h03300, 20'h1F000);
    do_frame(0, gm, ga);
    @(negedge clk);
    generate_next = 1'b1;
    @(negedge clk);
    generate_next = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check_eq("mid_rst_mix", mix_sample, 32'd0);
    for (int k = 0; k < FRAME_CYC + 2; k++) begin
      check_eq("mid_rst_ready", sample_ready, 32'd0);
      check_eq("mid_rst_busy", busy, 32'd0);
      @(negedge clk);
    end
    model_reset();
    do_frame(0, gm, ga);
    check_eq("post_rst_addr0", ga, 32'd0);

    // Random frames with random enables, steps, gaps and dropped requests.
    for (int f = 0; f < 40; f++) begin
      voice_en   = NV'($urandom_range(0, (1 << NV) - 1));
      step_sizes = {20'($urandom), 20'($urandom), 20'($urandom)};
      do_frame(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, FRAME_CYC)) : 0, gm, ga);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
